hash_param: RTL and testbench
=============================

HASH_PARAM -- requirements
Module: hash_param

Interface
REQ-001 The module SHALL have parameter DIGEST_BYTES, default 8: the number of digest bytes N, legal range 2..32.
REQ-002 The module SHALL have parameter ROUNDS, default 32: the number of rounds applied per input byte, legal range 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset_l, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts an input byte this cycle.
REQ-007 Port in_data, input, 8 bits: the message byte.
REQ-008 Port in_last, input, 1 bit: the byte is the final byte of the message.
REQ-009 Port out_valid, output, 1 bit: out_digest holds a completed digest.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the digest.
REQ-011 Port out_digest, output, 8*N bits: the digest, with byte 0 at the MSBs.
REQ-012 Port busy, output, 1 bit: high while rounds are executing.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, ROUND and DONE.
- in_ready = 1 only in IDLE.
- busy = 1 only in ROUND.
- out_valid = 1 only in DONE.
REQ-014 An input byte SHALL be accepted only on an edge where in_valid and in_ready are both high.
- On accept: latch in_data and in_last, clear the round counter, go to ROUND.
REQ-015 Each edge in ROUND SHALL perform one round on the latched byte m and increment the round counter.
- Round: for every j in 0..N-1, computed from the pre-round digest d: d'[j] = SBOX[rotl8(d[(j+2) mod N] ^ m, j mod 8)].
- SBOX is the standard AES forward S-box.
REQ-016 The round counter SHALL be $clog2(ROUNDS+1) bits wide and SHALL never wrap.
- After the ROUNDS-th round edge the block goes to DONE if the latched in_last = 1, otherwise to IDLE.
- in_ready is therefore low for exactly ROUNDS cycles per byte.
REQ-017 out_digest SHALL be registered and SHALL load the final digest on the same edge that enters DONE.
- It holds stable while out_valid = 1 and out_ready = 0.
REQ-018 On an edge with out_valid and out_ready both high, the block SHALL:
- go to IDLE;
- reload the digest with the IV;
- clear out_valid;
- keep out_digest unchanged until the next completion.
REQ-019 The IV SHALL be byte k = IV8[k mod 8], where IV8 = 34,55,0F,14,DA,C0,2B,EE (hex) for k = 0..7.
REQ-020 in_valid while in_ready = 0 SHALL be ignored, with no side effect; the source must hold the byte until accepted.
REQ-021 Successive messages SHALL be independent: each starts from the IV, and no magic start or end bytes exist.
- The values 0x00 and 0xFF are ordinary data.
REQ-022 If in_valid = 1 in IDLE on the edge that enters IDLE from DONE, the byte SHALL NOT be accepted on that edge.
- It is accepted on the following edge.

Reset
REQ-023 On an edge with reset_l = 0, the block SHALL enter IDLE regardless of current state, including mid-ROUND or in DONE:
- digest = IV;
- round counter = 0;
- out_digest = 0;
- out_valid = 0;
- busy = 0;
- in_ready = 1 from the first cycle after reset releases.
REQ-024 A reset mid-message SHALL discard all partial state; the interrupted message produces no digest.

Verification
REQ-025 Known answer: N=8, ROUNDS=1, one byte 00 with in_last=1 -> out_valid on cycle accept+2; out_digest = 76347F6F37C1D7AC.
REQ-026 Timing: defaults (N=8, ROUNDS=32), 3-byte message -> in_ready low for exactly 32 cycles after each accept; out_valid rises 33 cycles after the third accept; busy is high only during rounds.
REQ-027 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_digest and out_valid stable; in_ready = 0; in_valid pulses ignored.
REQ-028 Reset mid-operation: reset_l = 0 for 1 cycle at round 15 of byte 2 -> all outputs equal reset values; re-sending the full message yields the same digest as an uninterrupted run.
REQ-029 Parameter sweep: N in {2,5,16}, ROUNDS in {1,7}, random messages including 00 and FF bytes -> out_digest matches the software reference model; two back-to-back identical messages give identical digests.

Source files
------------

// File: rtl/hash_param_if.sv
// Byte-stream input and digest output channel of the hash_param block.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the input-byte and the digest channel.
interface hash_param_if #(
    parameter int DIGEST_BYTES = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [7:0]                in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [8*DIGEST_BYTES-1:0] out_digest;
    logic                      busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_digest, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_digest, busy
    );
endinterface

// File: rtl/hash_param.sv
// Iterated S-box byte hash: each accepted byte is mixed into an N-byte digest over ROUNDS rounds.
// Latency: ROUNDS cycles per byte after accept; digest valid on the cycle after the last round.
// Backpressure: in_ready only in IDLE; a completed digest is held until out_ready.
module hash_param #(
    parameter int DIGEST_BYTES = 8,
    parameter int ROUNDS       = 32
) (
    input  logic         clk,
    input  logic         reset_l,
    hash_param_if.slave  bus
);
    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [63:0] IV8 = 64'h3455_0F14_DAC0_2BEE;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [7:0]                msg_q, msg_d;
    logic                      last_q, last_d;
    logic [7:0]                dig_q  [DIGEST_BYTES];
    logic [7:0]                dig_d  [DIGEST_BYTES];
    logic [7:0]                rnd    [DIGEST_BYTES];
    logic [7:0]                iv_arr [DIGEST_BYTES];
    logic [8*DIGEST_BYTES-1:0] rnd_flat;
    logic [8*DIGEST_BYTES-1:0] out_q, out_d;

    // One full round is combinational over all N bytes; every byte reads the pre-round digest.
    for (genvar j = 0; j < DIGEST_BYTES; j++) begin : g_byte
        localparam int SRC = (j + 2) % DIGEST_BYTES;
        localparam int SH  = j % 8;
        logic [7:0] mix;
        logic [7:0] rot;

        assign mix = dig_q[SRC] ^ msg_q;
        if (SH == 0) begin : g_norot
            assign rot = mix;
        end else begin : g_rot
            assign rot = {mix[7-SH:0], mix[7:8-SH]};
        end
        assign rnd[j]    = SBOX[rot];
        assign iv_arr[j] = IV8[8*(7-(j%8)) +: 8];
        assign rnd_flat[8*(DIGEST_BYTES-1-j) +: 8] = rnd[j];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        last_d  = last_q;
        dig_d   = dig_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    msg_d   = bus.in_data;
                    last_d  = bus.in_last;
                    cnt_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                dig_d = rnd;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ROUNDS - 1)) begin
                    if (last_q) begin
                        state_d = DONE;
                        out_d   = rnd_flat;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                // Re-arm from the IV so the next message is independent of this one.
                if (bus.out_ready) begin
                    state_d = IDLE;
                    dig_d   = iv_arr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            msg_q   <= '0;
            last_q  <= 1'b0;
            dig_q   <= iv_arr;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            last_q  <= last_d;
            dig_q   <= dig_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q == ROUND);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_digest = out_q;
endmodule

// File: tb/tb_hash_param.sv
// Bench for hash_param over several DIGEST_BYTES/ROUNDS configurations, checked against a
// reference model that derives the S-box from GF(2^8) arithmetic.
module tb_hash_param;
    localparam int NCFG = 8;
    localparam int NS [NCFG] = '{8, 8, 2, 2, 5, 5, 16, 16};
    localparam int RS [NCFG] = '{32, 1, 1, 7, 1, 7, 1, 7};
    localparam logic [7:0] IV8 [8] = '{8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC0, 8'h2B, 8'hEE};

    logic         clk = 1'b0;
    logic         reset_l;
    logic         in_valid_a  [NCFG];
    logic [7:0]   in_data_a   [NCFG];
    logic         in_last_a   [NCFG];
    logic         out_ready_a [NCFG];
    logic         in_ready_a  [NCFG];
    logic         out_valid_a [NCFG];
    logic         busy_a      [NCFG];
    logic [255:0] dig_a       [NCFG];

    logic [7:0]   sbox [256];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        hash_param_if #(.DIGEST_BYTES(NS[g])) bus ();

        hash_param #(.DIGEST_BYTES(NS[g]), .ROUNDS(RS[g])) dut (
            .clk     (clk),
            .reset_l (reset_l),
            .bus     (bus)
        );

        assign bus.in_valid   = in_valid_a[g];
        assign bus.in_data    = in_data_a[g];
        assign bus.in_last    = in_last_a[g];
        assign bus.out_ready  = out_ready_a[g];
        assign in_ready_a[g]  = bus.in_ready;
        assign out_valid_a[g] = bus.out_valid;
        assign busy_a[g]      = bus.busy;
        assign dig_a[g]       = 256'(bus.out_digest);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (s == 0) ? v : ((v << s) | (v >> (8 - s)));
    endfunction

    // AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [255:0] ref_digest(input int n, input int r, input logic [7:0] msg [$]);
        logic [7:0]   d  [32];
        logic [7:0]   nd [32];
        logic [255:0] res = '0;
        for (int k = 0; k < n; k++) d[k] = IV8[k % 8];
        foreach (msg[b]) begin
            for (int rr = 0; rr < r; rr++) begin
                for (int j = 0; j < n; j++) nd[j] = sbox[rotl8(d[(j + 2) % n] ^ msg[b], j % 8)];
                for (int j = 0; j < n; j++) d[j] = nd[j];
            end
        end
        for (int j = 0; j < n; j++) res = (res << 8) | 256'(d[j]);
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte, waits for acceptance, then counts cycles until the block is
    // ready again (non-final byte) or presents a digest (final byte).
    task automatic send_timed(input int i, input logic [7:0] b, input logic last,
                              output int cyc, output int bc);
        int w = 0;
        in_valid_a[i] = 1'b1;
        in_data_a[i]  = b;
        in_last_a[i]  = last;
        while (!in_ready_a[i] && w < 2000) begin
            tick();
            w++;
        end
        check("ready_before_accept", 256'(in_ready_a[i]), 256'd1);
        tick();
        in_valid_a[i] = 1'b0;
        cyc = 1;
        bc  = 0;
        while (!(last ? out_valid_a[i] : in_ready_a[i]) && cyc < 2000) begin
            if (busy_a[i]) bc++;
            tick();
            cyc++;
        end
    endtask

    task automatic run_msg(input int i, input logic [7:0] msg [$], output logic [255:0] dg);
        int cyc, bc;
        foreach (msg[k]) begin
            send_timed(i, msg[k], (k == msg.size() - 1), cyc, bc);
            check($sformatf("busy_cycles_cfg%0d", i), 256'(bc), 256'(RS[i]));
        end
        check($sformatf("out_valid_cfg%0d", i), 256'(out_valid_a[i]), 256'd1);
        dg = dig_a[i];
        out_ready_a[i] = 1'b1;
        tick();
        out_ready_a[i] = 1'b0;
        check($sformatf("out_valid_clear_cfg%0d", i), 256'(out_valid_a[i]), 256'd0);
    endtask

    task automatic sweep(input int i);
        logic [7:0]   msg [$];
        logic [255:0] dg, exp;
        int           len;
        for (int t = 0; t < 3; t++) begin
            msg.delete();
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) msg.push_back(8'($urandom_range(0, 255)));
            if (t == 0) begin
                msg.push_front(8'h00);
                msg.push_back(8'hFF);
            end
            exp = ref_digest(NS[i], RS[i], msg);
            for (int rep = 0; rep < 2; rep++) begin
                run_msg(i, msg, dg);
                check($sformatf("sweep_cfg%0d_msg%0d_rep%0d", i, t, rep), dg, exp);
            end
        end
    endtask

    initial begin
        logic [7:0]   msg3 [$];
        logic [7:0]   one [$];
        logic [255:0] dg, exp3, held;
        int           cyc, bc, w;

        build_sbox();
        for (int i = 0; i < NCFG; i++) begin
            in_valid_a[i]  = 1'b0;
            in_data_a[i]   = 8'h00;
            in_last_a[i]   = 1'b0;
            out_ready_a[i] = 1'b0;
        end
        reset_l = 1'b0;
        tick();
        tick();
        reset_l = 1'b1;
        tick();
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("rst_in_ready_cfg%0d", i), 256'(in_ready_a[i]), 256'd1);
            check($sformatf("rst_busy_cfg%0d", i), 256'(busy_a[i]), 256'd0);
            check($sformatf("rst_out_valid_cfg%0d", i), 256'(out_valid_a[i]), 256'd0);
            check($sformatf("rst_digest_cfg%0d", i), dig_a[i], 256'd0);
        end

        // Known answer, N=8 ROUNDS=1.
        in_valid_a[1] = 1'b1;
        in_data_a[1]  = 8'h00;
        in_last_a[1]  = 1'b1;
        cyc = 0;
        do begin
            tick();
            in_valid_a[1] = 1'b0;
            cyc++;
        end while (!out_valid_a[1] && cyc < 100);
        check("kat_latency", 256'(cyc), 256'd2);
        check("kat_digest", dig_a[1], 256'h76347F6F37C1D7AC);
        one.delete();
        one.push_back(8'h00);
        check("kat_model", dig_a[1], ref_digest(8, 1, one));

        // A byte offered on the DONE->IDLE edge must wait one more edge.
        in_valid_a[1]  = 1'b1;
        in_data_a[1]   = 8'hA5;
        in_last_a[1]   = 1'b1;
        out_ready_a[1] = 1'b1;
        tick();
        out_ready_a[1] = 1'b0;
        check("exit_not_accepted", 256'(in_ready_a[1]), 256'd1);
        check("exit_out_valid", 256'(out_valid_a[1]), 256'd0);
        check("exit_digest_held", dig_a[1], 256'h76347F6F37C1D7AC);
        tick();
        in_valid_a[1] = 1'b0;
        check("accept_next_busy", 256'(busy_a[1]), 256'd1);
        w = 0;
        while (!out_valid_a[1] && w < 100) begin
            tick();
            w++;
        end
        one.delete();
        one.push_back(8'hA5);
        check("fresh_msg_valid", 256'(out_valid_a[1]), 256'd1);
        check("fresh_msg_digest", dig_a[1], ref_digest(8, 1, one));
        out_ready_a[1] = 1'b1;
        tick();
        out_ready_a[1] = 1'b0;

        // Default configuration: per-byte timing, then digest held under backpressure.
        msg3.push_back(8'h12);
        msg3.push_back(8'hFF);
        msg3.push_back(8'h00);
        exp3 = ref_digest(8, 32, msg3);
        for (int k = 0; k < 3; k++) begin
            send_timed(0, msg3[k], (k == 2), cyc, bc);
            check($sformatf("busy_byte%0d", k), 256'(bc), 256'd32);
            if (k < 2) check($sformatf("ready_low_byte%0d", k), 256'(cyc - 1), 256'd32);
            else check("out_valid_delay", 256'(cyc), 256'd33);
        end
        check("busy_in_done", 256'(busy_a[0]), 256'd0);
        check("msg3_digest", dig_a[0], exp3);
        for (int c = 0; c < 10; c++) begin
            in_valid_a[0] = c[0];
            in_data_a[0]  = 8'h5A;
            in_last_a[0]  = 1'b1;
            tick();
            check($sformatf("bp_digest_c%0d", c), dig_a[0], exp3);
            check($sformatf("bp_valid_c%0d", c), 256'(out_valid_a[0]), 256'd1);
            check($sformatf("bp_in_ready_c%0d", c), 256'(in_ready_a[0]), 256'd0);
        end
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        tick();
        out_ready_a[0] = 1'b0;
        check("bp_release_valid", 256'(out_valid_a[0]), 256'd0);
        check("bp_release_digest", dig_a[0], exp3);
        check("bp_release_ready", 256'(in_ready_a[0]), 256'd1);

        // Reset during round 15 of byte 2, then resend the whole message.
        send_timed(0, msg3[0], 1'b0, cyc, bc);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = msg3[1];
        in_last_a[0]  = 1'b0;
        tick();
        in_valid_a[0] = 1'b0;
        repeat (15) tick();
        check("mid_busy_before_reset", 256'(busy_a[0]), 256'd1);
        reset_l = 1'b0;
        tick();
        reset_l = 1'b1;
        check("mid_rst_in_ready", 256'(in_ready_a[0]), 256'd1);
        check("mid_rst_busy", 256'(busy_a[0]), 256'd0);
        check("mid_rst_out_valid", 256'(out_valid_a[0]), 256'd0);
        check("mid_rst_digest", dig_a[0], 256'd0);
        run_msg(0, msg3, dg);
        check("after_reset_digest", dg, exp3);

        for (int i = 1; i < NCFG; i++) sweep(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
